// File: rtl/field_set_controller.sv
// Set-mode controller for the century clock: walks the user through the settable
// fields with select and turns up/down presses and holds into per-field inc/dec strobes.
module field_set_controller #(
  parameter int NUM_FIELDS   = 6,
  parameter int FIELD_W      = 3,
  parameter int BLINK_DIV    = 25000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000,
  parameter int TIMEOUT      = 500000000,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  select,
  input  logic                  up,
  input  logic                  down,
  output logic [NUM_FIELDS-1:0] inc,
  output logic [NUM_FIELDS-1:0] dec,
  output logic                  setting,
  output logic [FIELD_W-1:0]    field_idx,
  output logic [FIELD_W-1:0]    blink,
  output logic                  blink_on
);

  localparam logic [CNT_W-1:0]   BLINK_LAST   = CNT_W'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0]   DELAY_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]   RATE_LAST    = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [FIELD_W-1:0] LAST_FIELD   = FIELD_W'(NUM_FIELDS - 1);

  typedef enum logic {IDLE, SET} state_t;

  state_t                  state, state_nx;
  logic                    prev_sel, prev_u, prev_d;
  logic                    u_lvl, d_lvl, sel_rise, u_rise, d_rise;
  logic [CNT_W-1:0]        blink_cnt, blink_cnt_nx;
  logic [CNT_W-1:0]        rep_cnt, rep_cnt_nx;
  logic [CNT_W-1:0]        to_cnt, to_cnt_nx;
  logic                    rep_act, rep_act_nx;
  logic                    rep_dir, rep_dir_nx;
  logic                    rep_slow, rep_slow_nx;
  logic [FIELD_W-1:0]      field_nx;
  logic [NUM_FIELDS-1:0]   inc_nx, dec_nx, one_hot;
  logic                    blink_on_nx;
  logic                    held, strobe, strobe_dn, go_idle;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Both buttons together count as neither, so releasing one yields a fresh edge.
  assign u_lvl    = up & ~down;
  assign d_lvl    = down & ~up;
  assign sel_rise = select & ~prev_sel;
  assign u_rise   = u_lvl & ~prev_u;
  assign d_rise   = d_lvl & ~prev_d;
  assign one_hot  = NUM_FIELDS'(1) << field_idx;

  always_comb begin
    state_nx     = state;
    field_nx     = field_idx;
    inc_nx       = '0;
    dec_nx       = '0;
    blink_on_nx  = blink_on;
    blink_cnt_nx = blink_cnt;
    rep_cnt_nx   = rep_cnt;
    rep_act_nx   = rep_act;
    rep_dir_nx   = rep_dir;
    rep_slow_nx  = rep_slow;
    to_cnt_nx    = to_cnt;
    held         = rep_dir ? d_lvl : u_lvl;
    strobe       = 1'b0;
    strobe_dn    = 1'b0;
    go_idle      = 1'b0;

    case (state)
      IDLE: begin
        if (sel_rise && !en) begin
          state_nx     = SET;
          blink_on_nx  = 1'b1;
          blink_cnt_nx = '0;
          to_cnt_nx    = '0;
        end
      end
      SET: begin
        if (blink_cnt >= BLINK_LAST) begin
          blink_on_nx  = ~blink_on;
          blink_cnt_nx = '0;
        end else begin
          blink_cnt_nx = sat_inc(blink_cnt);
        end

        if (en) begin
          go_idle = 1'b1;
        end else if (sel_rise) begin
          rep_act_nx  = 1'b0;
          rep_cnt_nx  = '0;
          rep_slow_nx = 1'b0;
          to_cnt_nx   = '0;
          if (field_idx == LAST_FIELD) go_idle = 1'b1;
          else field_nx = field_idx + FIELD_W'(1);
        end else begin
          // rep_slow marks that the long initial delay has elapsed.
          if (u_rise || d_rise) begin
            strobe      = 1'b1;
            strobe_dn   = d_rise;
            rep_act_nx  = 1'b1;
            rep_dir_nx  = d_rise;
            rep_cnt_nx  = '0;
            rep_slow_nx = 1'b0;
          end else if (rep_act && held) begin
            if (rep_cnt >= (rep_slow ? RATE_LAST : DELAY_LAST)) begin
              strobe      = 1'b1;
              strobe_dn   = rep_dir;
              rep_cnt_nx  = '0;
              rep_slow_nx = 1'b1;
            end else begin
              rep_cnt_nx = sat_inc(rep_cnt);
            end
          end else begin
            rep_act_nx  = 1'b0;
            rep_cnt_nx  = '0;
            rep_slow_nx = 1'b0;
          end

          if (strobe) begin
            if (strobe_dn) dec_nx = one_hot;
            else inc_nx = one_hot;
            blink_on_nx  = 1'b1;
            blink_cnt_nx = '0;
            to_cnt_nx    = '0;
          end else if (to_cnt >= TIMEOUT_LAST) begin
            go_idle = 1'b1;
          end else begin
            to_cnt_nx = sat_inc(to_cnt);
          end
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle || state_nx == IDLE) begin
      state_nx     = IDLE;
      field_nx     = '0;
      inc_nx       = '0;
      dec_nx       = '0;
      blink_on_nx  = 1'b0;
      blink_cnt_nx = '0;
      rep_cnt_nx   = '0;
      rep_act_nx   = 1'b0;
      rep_slow_nx  = 1'b0;
      to_cnt_nx    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev_sel  <= 1'b0;
      prev_u    <= 1'b0;
      prev_d    <= 1'b0;
      blink_cnt <= '0;
      rep_cnt   <= '0;
      to_cnt    <= '0;
      rep_act   <= 1'b0;
      rep_dir   <= 1'b0;
      rep_slow  <= 1'b0;
      inc       <= '0;
      dec       <= '0;
      setting   <= 1'b0;
      field_idx <= '0;
      blink     <= '0;
      blink_on  <= 1'b0;
    end else begin
      state     <= state_nx;
      prev_sel  <= select;
      prev_u    <= u_lvl;
      prev_d    <= d_lvl;
      blink_cnt <= blink_cnt_nx;
      rep_cnt   <= rep_cnt_nx;
      to_cnt    <= to_cnt_nx;
      rep_act   <= rep_act_nx;
      rep_dir   <= rep_dir_nx;
      rep_slow  <= rep_slow_nx;
      inc       <= inc_nx;
      dec       <= dec_nx;
      setting   <= (state_nx == SET);
      field_idx <= field_nx;
      blink     <= (state_nx == SET) ? field_nx + FIELD_W'(1) : '0;
      blink_on  <= blink_on_nx;
    end
  end

endmodule

// File: tb/tb_field_set_controller.sv
// Directed bench for field_set_controller: an age-based behavioural model checked every
// cycle, plus hand-computed literal expectations on the key cycles.
module tb_field_set_controller;

  localparam int NF = 6;
  localparam int FW = 3;
  localparam int BD = 4;
  localparam int RD = 8;
  localparam int RR = 3;
  localparam int TO = 40;

  localparam logic [19:0] M_ALL    = 20'hFFFFF;
  localparam logic [19:0] M_NOBO   = 20'hFEFFF;
  localparam logic [19:0] M_STROBE = 20'h00FFF;
  localparam logic [19:0] M_BO     = 20'h01000;
  localparam logic [19:0] M_SET    = 20'h80000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          select = 1'b0;
  logic          up = 1'b0;
  logic          down = 1'b0;
  logic [NF-1:0] inc, dec;
  logic          setting, blink_on;
  logic [FW-1:0] field_idx, blink;

  field_set_controller #(
    .NUM_FIELDS(NF), .FIELD_W(FW), .BLINK_DIV(BD), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .TIMEOUT(TO), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .select(select), .up(up), .down(down),
    .inc(inc), .dec(dec), .setting(setting), .field_idx(field_idx),
    .blink(blink), .blink_on(blink_on)
  );

  always #5 clk = ~clk;

  // Model state is kept as ages (cycles since an event) rather than reloading counters.
  bit           m_set = 1'b0;
  int           m_field = 0;
  int           phase_age = 0;
  int           idle_age = 0;
  int           hold_age = -1;
  bit           hold_dn = 1'b0;
  bit           p_sel = 1'b0, p_u = 1'b0, p_d = 1'b0;
  logic [NF-1:0] m_inc = '0, m_dec = '0;

  int           n_vec = 0;
  int           n_miss = 0;
  logic         pin_valid = 1'b0;
  logic [19:0]  pin_val = '0, pin_mask = '0;
  string        pin_name = "";
  logic [19:0]  cmp_act, cmp_exp;
  logic [20:1]  rep_pattern;
  logic [12:1]  blink_table;

  function automatic logic [19:0] pack(input logic s, input logic [2:0] f, input logic [2:0] b,
                                       input logic bo, input logic [5:0] i, input logic [5:0] d);
    return {s, f, b, bo, i, d};
  endfunction

  function automatic logic [19:0] model_out();
    logic bo;
    bo = m_set && ((phase_age / BD) % 2 == 0);
    return pack(m_set, m_set ? FW'(m_field) : 3'd0, m_set ? FW'(m_field + 1) : 3'd0,
                bo, m_inc, m_dec);
  endfunction

  task automatic model_reset();
    m_set = 1'b0; m_field = 0; phase_age = 0; idle_age = 0; hold_age = -1;
    hold_dn = 1'b0; p_sel = 1'b0; p_u = 1'b0; p_d = 1'b0; m_inc = '0; m_dec = '0;
  endtask

  task automatic model_step();
    bit u, d, sr, ur, dr, fire, dn;
    if (!rst_n) begin
      model_reset();
      return;
    end
    u = up & ~down; d = down & ~up;
    sr = select & ~p_sel; ur = u & ~p_u; dr = d & ~p_d;
    m_inc = '0; m_dec = '0;
    if (!m_set) begin
      if (sr && !en) begin
        m_set = 1'b1; m_field = 0; phase_age = 0; idle_age = 0; hold_age = -1;
      end
    end else if (en) begin
      m_set = 1'b0;
    end else begin
      phase_age++;
      if (sr) begin
        hold_age = -1; idle_age = 0;
        if (m_field == NF - 1) m_set = 1'b0;
        else m_field++;
      end else begin
        fire = 1'b0; dn = 1'b0;
        if (ur || dr) begin
          hold_age = 0; hold_dn = dr; fire = 1'b1; dn = dr;
        end else if (hold_age >= 0 && (hold_dn ? d : u)) begin
          hold_age++;
          if (hold_age == RD || (hold_age > RD && (hold_age - RD) % RR == 0)) begin
            fire = 1'b1; dn = hold_dn;
          end
        end else begin
          hold_age = -1;
        end
        if (fire) begin
          if (dn) m_dec = NF'(1) << m_field;
          else m_inc = NF'(1) << m_field;
          phase_age = 0; idle_age = 0;
        end else begin
          idle_age++;
          if (idle_age >= TO) m_set = 1'b0;
        end
      end
    end
    p_sel = select; p_u = u; p_d = d;
  endtask

  task automatic apply_stimulus(input logic s, input logic u, input logic d, input logic e);
    select = s; up = u; down = d; en = e;
    @(posedge clk);
    pin_valid = 1'b0;
    model_step();
    #1;
  endtask

  task automatic check_output(input string name, input logic [19:0] val, input logic [19:0] mask);
    pin_name = name; pin_val = val; pin_mask = mask; pin_valid = 1'b1;
  endtask

  initial forever begin
    @(negedge clk);
    cmp_act = {setting, field_idx, blink, blink_on, inc, dec};
    cmp_exp = model_out();
    n_vec++;
    if (cmp_act !== cmp_exp) begin
      n_miss++;
      $display("[TB] FAIL model t=%0t actual=%h expected=%h", $time, cmp_act, cmp_exp);
    end
    if (pin_valid) begin
      n_vec++;
      if ((cmp_act & pin_mask) !== (pin_val & pin_mask)) begin
        n_miss++;
        $display("[TB] FAIL %s dut t=%0t actual=%h expected=%h mask=%h",
                 pin_name, $time, cmp_act, pin_val, pin_mask);
      end
      n_vec++;
      if ((cmp_exp & pin_mask) !== (pin_val & pin_mask)) begin
        n_miss++;
        $display("[TB] FAIL %s model t=%0t actual=%h expected=%h mask=%h",
                 pin_name, $time, cmp_exp, pin_val, pin_mask);
      end
    end
  end

  initial begin
    rep_pattern = 20'b0010_0100_1001_0000_0001;
    blink_table = 12'b0111_1000_0111;
    #1 rst_n = 1'b0;
    model_reset();

    // Reset, then walk through all six fields and out again.
    apply_stimulus(0, 0, 0, 0); check_output("reset", '0, M_ALL);
    apply_stimulus(0, 0, 0, 0); check_output("reset", '0, M_ALL);
    rst_n = 1'b1;
    apply_stimulus(0, 0, 0, 0); check_output("idle", '0, M_ALL);
    apply_stimulus(1, 0, 0, 0); check_output("enter", pack(1, 0, 1, 1, 0, 0), M_ALL);
    for (int k = 1; k < NF; k++) begin
      apply_stimulus(0, 0, 0, 0);
      apply_stimulus(1, 0, 0, 0);
      check_output("advance", pack(1, 3'(k), 3'(k + 1), 0, 0, 0), M_NOBO);
    end
    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0); check_output("wrap_exit", '0, M_ALL);
    apply_stimulus(0, 0, 0, 0);

    // Single up and down pulses in field 2.
    apply_stimulus(1, 0, 0, 0); apply_stimulus(0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0); apply_stimulus(0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0); apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0); check_output("inc_f2", pack(1, 2, 3, 1, 6'b000100, 0), M_ALL);
    apply_stimulus(0, 0, 0, 0); check_output("inc_f2_once", '0, M_STROBE);
    apply_stimulus(0, 0, 1, 0); check_output("dec_f2", pack(1, 2, 3, 1, 0, 6'b000100), M_ALL);
    apply_stimulus(0, 0, 0, 0); check_output("dec_f2_once", '0, M_STROBE);
    apply_stimulus(0, 0, 0, 1); check_output("abort", '0, M_ALL);
    apply_stimulus(0, 0, 0, 0);

    // Auto-repeat while holding up in field 0.
    apply_stimulus(1, 0, 0, 0); apply_stimulus(0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      apply_stimulus(0, 1, 0, 0);
      check_output("repeat", pack(0, 0, 0, 0, {5'b0, rep_pattern[i]}, 0), M_STROBE);
    end
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, 0, 0, 0); check_output("released", '0, M_STROBE);
    end
    apply_stimulus(0, 0, 0, 1); apply_stimulus(0, 0, 0, 0);

    // Both buttons cancel; dropping down yields an up strobe.
    apply_stimulus(1, 0, 0, 0); apply_stimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 1, 1, 0); check_output("both", '0, M_STROBE);
    end
    apply_stimulus(0, 1, 0, 0); check_output("drop_down", pack(1, 0, 1, 1, 6'b000001, 0), M_ALL);
    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1); apply_stimulus(0, 0, 0, 0);

    // Blink phase and plain timeout.
    apply_stimulus(1, 0, 0, 0);
    for (int n = 1; n <= TO; n++) begin
      apply_stimulus(0, 0, 0, 0);
      if (n <= 12) check_output("blink_phase", {7'b0, blink_table[n], 12'b0}, M_BO);
      if (n == TO - 1) check_output("timeout_pre", M_SET, M_SET);
      if (n == TO) check_output("timeout", '0, M_ALL);
    end

    // A strobe at cycle 30 restarts timeout and blink phase.
    apply_stimulus(1, 0, 0, 0);
    for (int n = 1; n <= 70; n++) begin
      apply_stimulus(0, n == 30, 0, 0);
      if (n == 30) check_output("strobe30", pack(1, 0, 1, 1, 6'b000001, 0), M_ALL);
      if (n == 33) check_output("blink_after_strobe", M_BO, M_BO);
      if (n == 34) check_output("blink_after_strobe", '0, M_BO);
      if (n == 69) check_output("timeout_restart_pre", M_SET, M_SET);
      if (n == 70) check_output("timeout_restart", '0, M_ALL);
    end

    // en aborts mid-hold and blocks entry.
    apply_stimulus(1, 0, 0, 0); apply_stimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 1); check_output("en_abort", '0, M_ALL);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(0, 1, 0, 1); check_output("en_hold", '0, M_SET | M_STROBE);
    end
    apply_stimulus(1, 1, 0, 1); check_output("en_blocks_entry", '0, M_ALL);
    apply_stimulus(0, 1, 0, 1);
    apply_stimulus(0, 0, 0, 0);

    // Asynchronous reset in the middle of an auto-repeat hold.
    apply_stimulus(1, 0, 0, 0); apply_stimulus(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) apply_stimulus(0, 1, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    check_output("async_reset", '0, M_ALL);
    apply_stimulus(0, 1, 0, 0); check_output("in_reset", '0, M_ALL);
    rst_n = 1'b1;
    apply_stimulus(0, 1, 0, 0); check_output("after_reset", '0, M_ALL);
    apply_stimulus(0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
